// File: rtl/servo_pwm_multi_if.sv
// Command/status bus of the multi-channel servo PWM block.
// The controller side uses the master modport; the PWM core uses the slave modport.
interface servo_pwm_multi_if #(
    parameter int NCH = 4,
    parameter int W   = 16
);
    logic           wr_en;
    logic [3:0]     wr_ch;
    logic [W-1:0]   wr_angle;
    logic [3:0]     rd_ch;
    logic [W-1:0]   rd_angle;
    logic           frame;
    logic [NCH-1:0] settled;
    logic [NCH-1:0] pwm;

    modport master (
        output wr_en, wr_ch, wr_angle, rd_ch,
        input  rd_angle, frame, settled, pwm
    );

    modport slave (
        input  wr_en, wr_ch, wr_angle, rd_ch,
        output rd_angle, frame, settled, pwm
    );
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator.
// One shared prescaler and frame counter drive NCH lanes. Each lane holds a
// target angle, a slewed current angle and a compare value that changes only
// at frame boundaries, so pulses are never cut short or stretched.
// Optional feature macro: SERVO_SLEW_EN. When defined, the current angle moves
// towards the target by at most SLEW_STEP per frame; when undefined it jumps
// to the target at the next frame boundary.

module servo_pwm_lane #(
    parameter int W         = 16,
    parameter int MIN_PULSE = 45,
    parameter int SLEW_STEP = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] wdata,
    input  logic         boundary,
    input  logic [W-1:0] cnt,
    output logic [W-1:0] cur,
    output logic         settled,
    output logic         pwm
);
    localparam logic [W-1:0] MINP = W'(MIN_PULSE);

    logic [W-1:0] target;
    logic [W-1:0] cur_next;
    logic [W-1:0] cvr;

    if (SLEW_STEP < 1) begin : g_bad_step
        $error("servo_pwm_lane: SLEW_STEP must be at least 1");
    end

    // Angle the lane will hold for the next frame.
`ifdef SERVO_SLEW_EN
    localparam logic [W-1:0] STEP = W'(SLEW_STEP);
    always_comb begin
        cur_next = cur;
        if (target > cur)
            cur_next = ((target - cur) > STEP) ? cur + STEP : target;
        else if (target < cur)
            cur_next = ((cur - target) > STEP) ? cur - STEP : target;
    end
`else
    always_comb begin
        cur_next = target;
    end
`endif

    // Target capture, frame-aligned angle/compare update and registered pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            target <= '0;
            cur    <= '0;
            cvr    <= MINP;
            pwm    <= 1'b0;
        end else begin
            if (we)
                target <= wdata;
            if (boundary) begin
                cur <= cur_next;
                cvr <= cur_next + MINP;
            end
            pwm <= (cnt < cvr);
        end
    end

    assign settled = (cur == target);
endmodule

module servo_pwm_multi #(
    parameter int NCH       = 4,
    parameter int W         = 16,
    parameter int PRESC     = 556,
    parameter int PERIOD    = 1800,
    parameter int MIN_PULSE = 45,
    parameter int ANGLE_MAX = 180,
    parameter int SLEW_STEP = 2
) (
    input logic               clk,
    input logic               rst,
    servo_pwm_multi_if.slave  bus
);
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [W-1:0] AMAX = W'(ANGLE_MAX);

    if (MIN_PULSE + ANGLE_MAX >= PERIOD) begin : g_bad_range
        $error("servo_pwm_multi: MIN_PULSE + ANGLE_MAX must be below PERIOD");
    end
    if (NCH < 1 || NCH > 16) begin : g_bad_nch
        $error("servo_pwm_multi: NCH must be 1..16");
    end
    if (PRESC < 1) begin : g_bad_presc
        $error("servo_pwm_multi: PRESC must be at least 1");
    end

    logic [PW-1:0]             pcnt;
    logic [W-1:0]              cnt;
    logic                      tick;
    logic                      boundary;
    logic                      frame_q;
    logic [W-1:0]              wdata;
    logic [NCH-1:0][W-1:0]     cur;
    logic [NCH-1:0]            settled_v;
    logic [NCH-1:0]            pwm_v;
    logic [W-1:0]              rd_sel;
    logic [W-1:0]              rd_q;

    assign tick     = (pcnt == PW'(PRESC - 1));
    assign boundary = tick && (cnt == W'(PERIOD - 1));
    assign wdata    = (bus.wr_angle > AMAX) ? AMAX : bus.wr_angle;

    // Prescaler, frame counter and the registered frame-boundary pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt    <= '0;
            cnt     <= '0;
            frame_q <= 1'b0;
        end else begin
            pcnt    <= tick ? '0 : pcnt + PW'(1);
            if (tick)
                cnt <= boundary ? '0 : cnt + W'(1);
            frame_q <= boundary;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        servo_pwm_lane #(
            .W         (W),
            .MIN_PULSE (MIN_PULSE),
            .SLEW_STEP (SLEW_STEP)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .we       (bus.wr_en && (bus.wr_ch == 4'(i))),
            .wdata    (wdata),
            .boundary (boundary),
            .cnt      (cnt),
            .cur      (cur[i]),
            .settled  (settled_v[i]),
            .pwm      (pwm_v[i])
        );
    end

    // Readback select; channels that do not exist read as zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NCH; i++)
            if (bus.rd_ch == 4'(i))
                rd_sel = cur[i];
    end

    // One-cycle registered readback.
    always_ff @(posedge clk) begin
        if (rst)
            rd_q <= '0;
        else
            rd_q <= rd_sel;
    end

    assign bus.rd_angle = rd_q;
    assign bus.frame    = frame_q;
    assign bus.settled  = settled_v;
    assign bus.pwm      = pwm_v;
endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
- Parametrised multi-channel servo PWM generator: NCH independent servo outputs from one system clock.
- Internal prescaler replaces the external servo divided clock.
- Per-channel slew limiter replaces the separate low-pass stage.
- Sits between the control/command logic (angle writes) and the servo pins; gives glitch-free, frame-aligned pulse updates.

Parameters:
- NCH, 4, number of servo channels (1..16)
- W, 16, width of angle, counter and compare datapath
- PRESC, 556, clk cycles per PWM tick (50 MHz / 556 ≈ 90 kHz)
- PERIOD, 1800, PWM ticks per frame (20 ms at 90 kHz)
- MIN_PULSE, 45, high ticks at angle 0 (0.5 ms, 2.5 %)
- ANGLE_MAX, 180, largest accepted angle; written values above it are clamped
- SLEW_STEP, 2, max angle change per frame per channel

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- wr_en  input  1  angle write strobe, one cycle
- wr_ch  input  4  target channel index
- wr_angle  input  W  target angle in degrees
- rd_ch  input  4  readback channel select
- rd_angle  output  W  current (slewed) angle of rd_ch, registered
- frame  output  1  one-cycle pulse at each frame boundary
- settled  output  NCH  bit i = 1 when cur[i] == target[i]
- pwm  output  NCH  servo pulse outputs

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- **Prescaler.** pcnt counts 0..PRESC-1 and wraps. tick = (pcnt == PRESC-1).
- **Frame counter.** cnt advances on tick, 0..PERIOD-1. A boundary occurs when tick && cnt == PERIOD-1: cnt goes to 0 and frame = 1 for exactly that clk cycle (registered, asserted the cycle after the wrapping edge).
- **Writes.**
  - On wr_en with wr_ch < NCH: target[wr_ch] <= min(wr_angle, ANGLE_MAX).
  - wr_ch >= NCH: write ignored, no state change.
  - Writes are accepted every cycle; the last write before a boundary wins.
- **Slew, at the boundary edge only, per channel.**
  - If target > cur: cur <= cur + min(SLEW_STEP, target - cur).
  - If target < cur: symmetric decrement.
  - Otherwise cur is unchanged.
- **Compare latch.** In the same boundary edge, cvr[i] <= cur_next[i] + MIN_PULSE. The new frame uses the new compare.
  - cvr never changes mid-frame, so there are no runt or stretched pulses.
- **Write coincident with boundary.** The slew uses the pre-edge target. The new target takes effect at the next boundary.
- **PWM.** pwm[i] is registered: pwm[i] <= (cnt < cvr[i]). Output lags cnt by one clk.
  - High time = cvr[i] ticks per PERIOD.
  - Range: MIN_PULSE .. MIN_PULSE+ANGLE_MAX (45..225 = 2.5 %..12.5 %).
- **Arithmetic.**
  - All values are unsigned W bits.
  - MIN_PULSE + ANGLE_MAX < PERIOD is required; an elaboration check fails otherwise.
  - No wrap is possible after the clamp.
- **Settled and readback.**
  - settled[i] is combinational from registers.
  - rd_angle <= cur[rd_ch] (0 if rd_ch >= NCH), 1-cycle latency.
- **Reset (synchronous, any time including mid-frame).**
  - pcnt = cnt = 0; target = cur = 0; cvr = MIN_PULSE.
  - pwm = 0, frame = 0, rd_angle = 0 while rst is high.
  - The first frame after release starts at cnt = 0 with 45-tick pulses.

Optional Feature:
- Macro: SERVO_SLEW_EN.
- Defined: slew limiting as above; settled may be 0 for several frames.
- Undefined: at each boundary cur <= target directly (single-frame step); SLEW_STEP is unused; settled = 1 from the boundary following any write.
- Frame alignment of cvr is preserved in both builds.

Test Plan (PRESC=2, PERIOD=1800, MIN_PULSE=45, NCH=4, SLEW_EN defined unless noted):
- **Reset release.** Release, no writes -> all pwm high 45 ticks (90 clk) per 1800-tick frame; frame period 3600 clk; settled = 4'b1111.
- **Slew to 90.** Write ch1 = 90 -> ch1 pulse grows 45, 47, 49, ... by 2 ticks/frame; reaches 135 ticks after 45 frames; settled[1] rises then; other channels unchanged.
- **Clamp.** Write ch2 = 250 -> target clamped to 180; steady-state pulse 225 ticks; rd_ch=2 gives rd_angle = 180 once settled.
- **Invalid channel.** wr_ch = 7 -> no channel's pulse or settled changes.
- **Write on boundary.** Write ch0 = 10 in the same cycle as the boundary edge -> the frame starting then still 45 ticks; next frame 47.
  - SLEW_EN undefined: the next frame is 55.
- **Reset mid-frame.** rst at cnt = 900 with ch1 at 135 ticks -> pwm = 0 during reset; after release ch1 = 45 ticks and frame realigned to cnt = 0.
